fc_engine: RTL and testbench

FC_ENGINE -- requirements
Module: fc_engine

---
 rtl/fc_engine_if.sv | 18 +
 rtl/fc_engine.sv | 207 ++++++++++++++++++++
 tb/tb_fc_engine.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fc_engine_if.sv
// fc_engine_if -- result stream between the fully-connected engine and its consumer.
//   out_valid : engine -> consumer, out_data/out_group are valid
//   out_ready : consumer -> engine, current group accepted when both are high
//   out_data  : LANES results, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_group : index of the group carried by out_data
interface fc_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int GROUP_W    = 4
);
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*DATA_WIDTH-1:0]   out_data;
    logic [GROUP_W-1:0]            out_group;

    modport master (output out_valid, output out_data, output out_group, input out_ready);
    modport slave  (input out_valid, input out_data, input out_group, output out_ready);
endinterface

// File: rtl/fc_engine.sv
// fc_engine -- fully-connected layer engine. LANES output neurons are computed in
// parallel per group; the engine walks every input feature once per group, then
// presents the group's saturated (optionally ReLU'd) results on the stream
// interface and tracks the argmax over all results of the inference.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, relu_en    : begin an inference when idle; relu_en latched with start
//   busy, done        : inference in progress; one-cycle pulse at the end
//   in_addr, in_data  : feature memory (one-cycle read latency)
//   w_addr, w_data    : weight memory, LANES weights per word (one-cycle latency)
//   out_if            : result stream (out_valid/out_ready/out_data/out_group)
//   max_index, max_valid : argmax over all results, held until next start
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_MAC   | issuing feature/weight addresses, accumulating returned pairs
// S_FLUSH | accumulating the final returned pair, latching group results
// S_OUT   | presenting group results until the consumer accepts them
// S_FIN   | done pulse; back to idle
module fc_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 40,
    parameter int IN_NEURONS  = 400,
    parameter int OUT_NEURONS = 120,
    parameter int LANES       = 8,
    localparam int GROUPS = OUT_NEURONS / LANES,
    localparam int IA_W   = (IN_NEURONS > 1) ? $clog2(IN_NEURONS) : 1,
    localparam int WA_W   = (GROUPS * IN_NEURONS > 1) ? $clog2(GROUPS * IN_NEURONS) : 1,
    localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int MI_W   = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          relu_en,
    output logic                          busy,
    output logic                          done,
    output logic [IA_W-1:0]               in_addr,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [WA_W-1:0]               w_addr,
    input  logic [LANES*DATA_WIDTH-1:0]   w_data,
    fc_engine_if.master                   out_if,
    output logic [MI_W-1:0]               max_index,
    output logic                          max_valid
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [IA_W-1:0] LAST_I = IA_W'(IN_NEURONS - 1);
    localparam logic [G_W-1:0]  LAST_G = G_W'(GROUPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] DW_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_FLUSH, S_OUT, S_FIN} state_t;

    state_t state, state_nxt;

    logic                          relu_q;
    logic                          rd_valid;     // a feature/weight pair arrives this cycle
    logic [G_W-1:0]                group;
    logic [LANES*DATA_WIDTH-1:0]   out_data_q;
    logic signed [DATA_WIDTH-1:0]  max_val;

    logic signed [ACC_WIDTH-1:0]   acc     [LANES];
    logic signed [ACC_WIDTH-1:0]   acc_nxt [LANES];
    logic signed [PROD_W-1:0]      prod    [LANES];
    logic signed [DATA_WIDTH-1:0]  res     [LANES];
    logic signed [DATA_WIDTH-1:0]  best_val;
    logic [MI_W-1:0]               best_idx;

    function automatic logic signed [DATA_WIDTH-1:0] finalize(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic                        relu
    );
        logic signed [ACC_WIDTH-1:0]  s;
        logic signed [DATA_WIDTH-1:0] r;
        s = a >>> FRAC_BITS;
        if (s > SAT_MAX)
            r = SAT_MAX[DATA_WIDTH-1:0];
        else if (s < SAT_MIN)
            r = SAT_MIN[DATA_WIDTH-1:0];
        else
            r = s[DATA_WIDTH-1:0];
        if (relu && r[DATA_WIDTH-1])
            r = '0;
        return r;
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_MAC;
            S_MAC:   if (in_addr == LAST_I) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_OUT;
            S_OUT:   if (out_if.out_ready) state_nxt = (group == LAST_G) ? S_FIN : S_MAC;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        busy             = (state != S_IDLE);
        done             = (state == S_FIN);
        out_if.out_valid = (state == S_OUT);
        out_if.out_data  = out_data_q;
        out_if.out_group = group;
    end

    // lane arithmetic and per-lane results
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod[k]    = $signed(in_data) * $signed(w_data[k*DATA_WIDTH +: DATA_WIDTH]);
            acc_nxt[k] = acc[k] + {{(ACC_WIDTH - PROD_W){prod[k][PROD_W-1]}}, prod[k]};
            res[k]     = finalize(acc_nxt[k], relu_q);
        end
    end

    // running argmax; ascending lane order with strict > keeps the lowest index on ties
    always_comb begin
        best_val = max_val;
        best_idx = max_index;
        for (int k = 0; k < LANES; k++) begin
            if (res[k] > best_val) begin
                best_val = res[k];
                best_idx = MI_W'(int'(group) * LANES + k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
            relu_q     <= 1'b0;
            rd_valid   <= 1'b0;
            group      <= '0;
            in_addr    <= '0;
            w_addr     <= '0;
            out_data_q <= '0;
            max_val    <= '0;
            max_index  <= '0;
            max_valid  <= 1'b0;
        end else begin
            rd_valid <= (state == S_MAC);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < LANES; k++) acc[k] <= '0;
                        relu_q    <= relu_en;
                        group     <= '0;
                        in_addr   <= '0;
                        w_addr    <= '0;
                        max_val   <= DW_MIN;
                        max_index <= '0;
                        max_valid <= 1'b0;
                    end
                end
                S_MAC: begin
                    // first MAC cycle has no returned pair yet
                    if (rd_valid)
                        for (int k = 0; k < LANES; k++) acc[k] <= acc_nxt[k];
                    if (in_addr != LAST_I) begin
                        in_addr <= in_addr + IA_W'(1);
                        w_addr  <= w_addr + WA_W'(1);
                    end
                end
                S_FLUSH: begin
                    for (int k = 0; k < LANES; k++) begin
                        acc[k] <= acc_nxt[k];
                        out_data_q[k*DATA_WIDTH +: DATA_WIDTH] <= res[k];
                    end
                    max_val   <= best_val;
                    max_index <= best_idx;
                end
                S_OUT: begin
                    if (out_if.out_ready) begin
                        for (int k = 0; k < LANES; k++) acc[k] <= '0;
                        if (group == LAST_G) begin
                            max_valid <= 1'b1;
                        end else begin
                            group   <= group + G_W'(1);
                            in_addr <= '0;
                            // weight words are laid out group-major, so the next
                            // group starts right after the last word just read
                            w_addr  <= w_addr + WA_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_engine.sv
// tb_fc_engine -- directed bench for fc_engine (DW=16, FRAC=8, IN=4, OUT=4, LANES=2).
// Feature/weight memories are modelled with one-cycle read latency.
module tb_fc_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic        relu_en;
    logic        busy;
    logic        done;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic [2:0]  w_addr;
    logic [31:0] w_data;
    logic [1:0]  max_index;
    logic        max_valid;

    logic [15:0] feat_mem [4];
    logic [31:0] w_mem    [8];

    int checks;
    int errors;

    fc_engine_if #(.DATA_WIDTH(16), .LANES(2), .GROUP_W(1)) oif ();

    fc_engine #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .ACC_WIDTH  (40),
        .IN_NEURONS (4),
        .OUT_NEURONS(4),
        .LANES      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .relu_en  (relu_en),
        .busy     (busy),
        .done     (done),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .out_if   (oif),
        .max_index(max_index),
        .max_valid(max_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        in_data <= feat_mem[in_addr];
        w_data  <= w_mem[w_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] f, input logic [15:0] w);
        for (int i = 0; i < 4; i++) feat_mem[i] = f;
        for (int i = 0; i < 8; i++) w_mem[i] = {w, w};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  busy,          0);
        chk({tag, "_done"},  done,          0);
        chk({tag, "_ov"},    oif.out_valid, 0);
        chk({tag, "_mv"},    max_valid,     0);
        chk({tag, "_od"},    oif.out_data,  0);
        chk({tag, "_og"},    oif.out_group, 0);
        chk({tag, "_mi"},    max_index,     0);
        chk({tag, "_ia"},    in_addr,       0);
        chk({tag, "_wa"},    w_addr,        0);
    endtask

    // Called at a negedge. poke=1 also pulses start while busy and during FIN.
    task automatic run(input string tag, input logic relu, input int stall, input logic poke,
                       input int exp_lat, input logic [31:0] exp0, input logic [31:0] exp1,
                       input int exp_max);
        int          cnt;
        int          stall_left;
        int          ngrp;
        logic        seen;
        logic [31:0] hold_d;
        logic        hold_g;
        logic [1:0]  hold_ia;
        logic [31:0] got [2];
        cnt = 0; ngrp = 0; seen = 0; stall_left = stall;
        hold_d = '0; hold_g = 1'b0; hold_ia = '0;
        got[0] = '0; got[1] = '0;
        relu_en   = relu;
        out_ready_set(stall == 0);
        start     = 1'b1;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start   = 1'b0;
                relu_en = ~relu;       // must not affect the latched mode
            end
            if (poke && cnt == 3) start = 1'b1;
            if (poke && cnt == 4) start = 1'b0;
            if (done) break;
            if (oif.out_valid) begin
                if (stall_left > 0) begin
                    if (!seen) begin
                        hold_d = oif.out_data; hold_g = oif.out_group; hold_ia = in_addr;
                        seen = 1'b1;
                    end else begin
                        chk({tag, "_stall_od"}, oif.out_data,  hold_d);
                        chk({tag, "_stall_og"}, oif.out_group, hold_g);
                        chk({tag, "_stall_ia"}, in_addr,       hold_ia);
                    end
                    stall_left--;
                    out_ready_set(1'b0);
                end else begin
                    out_ready_set(1'b1);
                    chk({tag, "_grp"}, oif.out_group, ngrp);
                    if (ngrp < 2) got[ngrp] = oif.out_data;
                    ngrp++;
                end
            end
        end
        chk({tag, "_lat"},  cnt,       exp_lat);
        chk({tag, "_done"}, done,      1);
        chk({tag, "_ngrp"}, ngrp,      2);
        chk({tag, "_g0"},   got[0],    exp0);
        chk({tag, "_g1"},   got[1],    exp1);
        chk({tag, "_mv"},   max_valid, 1);
        chk({tag, "_mi"},   max_index, exp_max);
        if (poke) start = 1'b1;        // start during FIN is ignored
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, done,      0);
        chk({tag, "_idle"},       busy,      0);
        chk({tag, "_mv_hold"},    max_valid, 1);
        chk({tag, "_mi_hold"},    max_index, exp_max);
        @(negedge clk);
        chk({tag, "_still_idle"}, busy, 0);
    endtask

    task automatic out_ready_set(input logic v);
        oif.out_ready = v;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; relu_en = 1'b0; oif.out_ready = 1'b1;
        fill(16'h0100, 16'h0080);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_zero("rst");

        // reset wins over start
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        @(negedge clk);
        chk("rst_prio_busy2", busy, 0);

        run("basic", 1'b0, 0, 1'b0, 13, 32'h0200_0200, 32'h0200_0200, 0);

        fill(16'h0100, 16'hFF80);
        run("neg",  1'b0, 0, 1'b0, 13, 32'hFE00_FE00, 32'hFE00_FE00, 0);
        run("relu", 1'b1, 0, 1'b0, 13, 32'h0000_0000, 32'h0000_0000, 0);

        fill(16'h7FFF, 16'h7FFF);
        run("satp", 1'b0, 0, 1'b0, 13, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 0);
        fill(16'h7FFF, 16'h8000);
        run("satn", 1'b0, 0, 1'b0, 13, 32'h8000_8000, 32'h8000_8000, 0);

        // neuron results 3,9,9,1: tie between 1 and 2 keeps index 1
        fill(16'h0000, 16'h0000);
        feat_mem[0] = 16'h0100;
        w_mem[0] = {16'd9, 16'd3};
        w_mem[4] = {16'd1, 16'd9};
        run("argmax", 1'b0, 0, 1'b0, 13, 32'h0009_0003, 32'h0001_0009, 1);

        fill(16'h0100, 16'h0080);
        run("stall", 1'b0, 5, 1'b0, 18, 32'h0200_0200, 32'h0200_0200, 0);

        // reset in the third MAC cycle, then a clean inference
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_ia", in_addr, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("midrst");
        run("after_rst", 1'b0, 0, 1'b1, 13, 32'h0200_0200, 32'h0200_0200, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
